// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM states,
// default latencies and a small arithmetic helper.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 32'd5;
  localparam int unsigned DIV_CYCLES_DEF  = 32'd10;

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational datapath: 64-bit products and quotient/remainder pairs packed as {HI,LO}.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] res,
  output logic        div_zero
);

  logic signed [63:0] smul_s;
  logic        [63:0] umul_s;
  logic               sdiv_s;
  logic        [31:0] dividend_s;
  logic        [31:0] divisor_s;
  logic        [31:0] quot_s;
  logic        [31:0] rem_s;

  assign smul_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign umul_s = {32'd0, rs} * {32'd0, rt};

  // One unsigned divider serves both forms; signed division works on magnitudes.
  assign sdiv_s     = (op == OP_DIV);
  assign div_zero   = is_div_op(op) && (rt == 32'd0);
  assign dividend_s = sdiv_s ? cond_neg(rs, rs[31]) : rs;
  assign divisor_s  = (rt == 32'd0) ? 32'd1 : (sdiv_s ? cond_neg(rt, rt[31]) : rt);
  assign quot_s     = dividend_s / divisor_s;
  assign rem_s      = dividend_s % divisor_s;

  // Select the {HI,LO} result for the requested operation.
  always_comb begin
    res = 64'd0;
    case (op)
      OP_MULT:  res = smul_s;
      OP_MULTU: res = umul_s;
      OP_DIV:   res = {cond_neg(rem_s, rs[31]), cond_neg(quot_s, rs[31] ^ rt[31])};
      OP_DIVU:  res = {rem_s, quot_s};
      default:  res = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit with private HI/LO registers. Results are computed at issue
// and committed after a fixed latency while busy is held high.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_MULT  = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV   = CNT_W'(DIV_CYCLES);

  mdu_state_e       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [63:0]      res_r, res_nxt_s;
  logic             dz_r, dz_nxt_s;
  logic [31:0]      hi_r, hi_nxt_s;
  logic [31:0]      lo_r, lo_nxt_s;
  logic             busy_r;
  logic [63:0]      calc_res_s;
  logic             calc_dz_s;

  mdu_calc u_calc (
    .op       (MDUOp),
    .rs       (rs),
    .rt       (rt),
    .res      (calc_res_s),
    .div_zero (calc_dz_s)
  );

  // Next-state logic: accept requests in IDLE, count down and commit in RUN.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    res_nxt_s   = res_r;
    dz_nxt_s    = dz_r;
    hi_nxt_s    = hi_r;
    lo_nxt_s    = lo_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          case (MDUOp)
            OP_MULT, OP_MULTU: begin
              res_nxt_s   = calc_res_s;
              dz_nxt_s    = 1'b0;
              cnt_nxt_s   = CNT_MULT;
              state_nxt_s = ST_RUN;
            end
            OP_DIV, OP_DIVU: begin
              res_nxt_s   = calc_res_s;
              dz_nxt_s    = calc_dz_s;
              cnt_nxt_s   = CNT_DIV;
              state_nxt_s = ST_RUN;
            end
            OP_MTHI: hi_nxt_s = rs;
            OP_MTLO: lo_nxt_s = rs;
            default: state_nxt_s = ST_IDLE;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        cnt_nxt_s = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          state_nxt_s = ST_IDLE;
          // A zero divisor still takes the full latency but leaves HI/LO alone.
          if (!dz_r) begin
            hi_nxt_s = res_r[63:32];
            lo_nxt_s = res_r[31:0];
          end else begin
            hi_nxt_s = hi_r;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, counter, result latch and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      res_r   <= 64'd0;
      dz_r    <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      res_r   <= res_nxt_s;
      dz_r    <= dz_nxt_s;
      hi_r    <= hi_nxt_s;
      lo_r    <= lo_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN);
    end
  end

  assign busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule
